// File: rtl/tb_run_controller_if.sv
// Bench-side bundle for the end-of-simulation controller: monitor flags in, verdict out.
// Carries the heartbeat vector only when TB_RUN_CTRL_HEARTBEAT_EN is defined.
interface tb_run_controller_if #(
  parameter int NUM_SRC   = 2,
  parameter int NUM_LANES = 8,
  parameter int CNT_W     = 32
);
  localparam int ERR_W  = $clog2(NUM_SRC + 1);
  localparam int LANE_W = $clog2(NUM_LANES);

  logic [NUM_SRC-1:0]           src_en;
  logic [NUM_SRC*NUM_LANES-1:0] halt;
  logic [NUM_SRC-1:0]           src_error;
  logic                         mem_error;
`ifdef TB_RUN_CTRL_HEARTBEAT_EN
  logic [NUM_SRC-1:0]           heartbeat;
`endif
  logic                         finish;
  logic                         done;
  logic [1:0]                   status;
  logic [ERR_W-1:0]             err_src;
  logic [LANE_W-1:0]            halt_lane;
  logic [CNT_W-1:0]             elapsed;

  modport master (
`ifdef TB_RUN_CTRL_HEARTBEAT_EN
    output heartbeat,
`endif
    output src_en, halt, src_error, mem_error,
    input  finish, done, status, err_src, halt_lane, elapsed
  );

  modport slave (
`ifdef TB_RUN_CTRL_HEARTBEAT_EN
    input  heartbeat,
`endif
    input  src_en, halt, src_error, mem_error,
    output finish, done, status, err_src, halt_lane, elapsed
  );
endinterface

// File: rtl/tb_run_controller.sv
// End-of-simulation controller: sticky per-lane halt join, error drain, cycle timeout.
// Optional TB_RUN_CTRL_HEARTBEAT_EN: heartbeat input reloads the timeout (idle timeout).
module tb_run_controller_lane #(
  parameter int NUM_SRC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [NUM_SRC-1:0] halt,
  input  logic [NUM_SRC-1:0] src_en,
  output logic               complete
);
  logic [NUM_SRC-1:0] sticky;

  always_ff @(posedge clk) begin
    if (rst)      sticky <= '0;
    else if (run) sticky <= sticky | halt;
  end

  // Same-cycle halt counts so the last monitor's pulse completes the lane immediately.
  assign complete = &(sticky | halt | ~src_en);
endmodule

module tb_run_controller #(
  parameter int NUM_SRC          = 2,
  parameter int NUM_LANES        = 8,
  parameter int TIMEOUT_CYCLES   = 10000000,
  parameter int ERR_DRAIN_CYCLES = 50,
  parameter int MEM_DRAIN_CYCLES = 5,
  parameter int CNT_W            = 32
) (
  input  logic clk,
  input  logic rst,
  tb_run_controller_if.slave bus
);
  localparam int ERR_W     = $clog2(NUM_SRC + 1);
  localparam int LANE_W    = $clog2(NUM_LANES);
  localparam int BOTH_DRAIN = (ERR_DRAIN_CYCLES > MEM_DRAIN_CYCLES) ? ERR_DRAIN_CYCLES
                                                                    : MEM_DRAIN_CYCLES;
  localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT_CYCLES);

  localparam logic [1:0] ST_RUNNING = 2'd0;
  localparam logic [1:0] ST_PASS    = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;
  localparam logic [1:0] ST_ERROR   = 2'd3;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;
  state_t state, state_nxt;

  logic [NUM_LANES-1:0][NUM_SRC-1:0] lane_halt;
  logic [NUM_LANES-1:0]              lane_done;
  logic                              run;

  assign run = (state == S_RUN);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      assign lane_halt[l][s] = bus.halt[s*NUM_LANES + l];
    end
    tb_run_controller_lane #(.NUM_SRC(NUM_SRC)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .halt     (lane_halt[l]),
      .src_en   (bus.src_en),
      .complete (lane_done[l])
    );
  end

  logic               any_src_err, any_err;
  logic [ERR_W-1:0]   err_idx;
  logic [LANE_W-1:0]  lane_idx;
  logic [CNT_W-1:0]   drain_len;

  assign any_src_err = |bus.src_error;
  assign any_err     = any_src_err | bus.mem_error;

  // Descending scans so the lowest set index is the one left standing.
  always_comb begin
    err_idx  = ERR_W'(NUM_SRC);
    lane_idx = '0;
    for (int s = NUM_SRC - 1; s >= 0; s--)
      if (bus.src_error[s]) err_idx = ERR_W'(s);
    for (int l = NUM_LANES - 1; l >= 0; l--)
      if (lane_done[l]) lane_idx = LANE_W'(l);
  end

  always_comb begin
    if (any_src_err && bus.mem_error) drain_len = CNT_W'(BOTH_DRAIN);
    else if (any_src_err)             drain_len = CNT_W'(ERR_DRAIN_CYCLES);
    else                              drain_len = CNT_W'(MEM_DRAIN_CYCLES);
  end

  logic             finish_q, done_q;
  logic [1:0]       status_q;
  logic [ERR_W-1:0] err_src_q;
  logic [LANE_W-1:0] halt_lane_q;
  logic [CNT_W-1:0] elapsed_q, to_cnt, drain_cnt;
  logic             go_err, go_pass, go_to;

  always_ff @(posedge clk) begin
    if (rst) state <= S_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    go_err    = 1'b0;
    go_pass   = 1'b0;
    go_to     = 1'b0;
    case (state)
      S_RUN: begin
        if (any_err) begin
          state_nxt = S_DRAIN;
          go_err    = 1'b1;
        end else if (|lane_done) begin
          state_nxt = S_DONE;
          go_pass   = 1'b1;
        end else if (to_cnt == '0) begin
          state_nxt = S_DONE;
          go_to     = 1'b1;
        end
      end
      // drain_cnt==1 here means it hits 0 on this edge: DONE lands N edges after the error.
      S_DRAIN: if (drain_cnt <= CNT_W'(1)) state_nxt = S_DONE;
      default: state_nxt = S_DONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      finish_q    <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= ST_RUNNING;
      err_src_q   <= '0;
      halt_lane_q <= '0;
      elapsed_q   <= '0;
      to_cnt      <= TIMEOUT_LD;
      drain_cnt   <= '0;
    end else begin
      finish_q <= (state != S_DONE) && (state_nxt == S_DONE);
      done_q   <= (state_nxt == S_DONE);
      if (state != S_DONE && elapsed_q != '1) elapsed_q <= elapsed_q + 1'b1;
      if (go_err) begin
        status_q  <= ST_ERROR;
        err_src_q <= err_idx;
        drain_cnt <= drain_len;
      end
      if (go_pass) begin
        status_q    <= ST_PASS;
        halt_lane_q <= lane_idx;
      end
      if (go_to) status_q <= ST_TIMEOUT;
      if (state == S_DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;
      if (run && !go_err && !go_pass && !go_to) begin
`ifdef TB_RUN_CTRL_HEARTBEAT_EN
        if (|bus.heartbeat)      to_cnt <= TIMEOUT_LD;
        else if (to_cnt != '0)   to_cnt <= to_cnt - 1'b1;
`else
        if (to_cnt != '0)        to_cnt <= to_cnt - 1'b1;
`endif
      end
    end
  end

  assign bus.finish    = finish_q;
  assign bus.done      = done_q;
  assign bus.status    = status_q;
  assign bus.err_src   = err_src_q;
  assign bus.halt_lane = halt_lane_q;
  assign bus.elapsed   = elapsed_q;
endmodule
